// File: rtl/but_led_ctrl.sv
// Button/switch-to-LED controller: synchronised, debounced buttons force an
// override pattern on the LED bank; otherwise a one-hot switch is shown bit-reversed.
module but_led_ctrl #(
   parameter int               N_BTN           = 6,
   parameter logic [N_BTN-1:0] BTN_ACT_LOW     = 6'b000011,
   parameter int               N_SW            = 4,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter logic [N_SW-1:0]  OVR_PATTERN     = N_SW'(1),
   parameter bit               BLINK_EN        = 1'b0,
   parameter int               BLINK_HALF      = 8,
   parameter int               HOLD_CYCLES     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   input  logic [N_SW-1:0]  sw,
   output logic [N_SW-1:0]  led,
   output logic [N_BTN-1:0] btn_db,
   output logic [N_BTN-1:0] btn_rise,
   output logic             ovr_active
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   // Terminal counts: the debounce compare fires one below the increment that would reach DEBOUNCE_CYCLES-1.
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 2);
   localparam logic [HW-1:0]  HOLD_LAST  = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
   localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);

   typedef enum logic [1:0] {ST_NORMAL, ST_OVERRIDE, ST_HOLD} state_t;

   logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
   logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
   logic [N_BTN-1:0] btn_db_q, btn_db_d;
   logic [N_BTN-1:0] btn_rise_q, btn_rise_d;
   logic [N_SW-1:0]  led_q, led_d;
   logic             ovr_active_q, ovr_active_d;
   state_t           state_q, state_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
   logic             phase_q, phase_d;
   logic [N_SW-1:0]  sw_dec;
   logic             sw_onehot;
   logic             any_btn;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn ^ BTN_ACT_LOW;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= sw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_db
         logic [DBW-1:0] cnt_q;
         logic           differ;
         logic           accept;

         assign differ          = btn_s2_q[gi] ^ btn_db_q[gi];
         assign accept          = differ && (cnt_q == DB_LAST);
         assign btn_db_d[gi]    = accept ? btn_s2_q[gi] : btn_db_q[gi];
         assign btn_rise_d[gi]  = accept && btn_s2_q[gi];

         always_ff @(posedge clk) begin
            if (rst || !differ || accept) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + DBW'(1);
            end
         end
      end

      for (gi = 0; gi < N_SW; gi++) begin : g_dec
         assign sw_dec[N_SW-1-gi] = sw_onehot & sw_s2_q[gi];
      end
   endgenerate

   assign sw_onehot = (sw_s2_q != '0) && ((sw_s2_q & (sw_s2_q - N_SW'(1))) == '0);
   assign any_btn   = |btn_db_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_db_q     <= '0;
         btn_rise_q   <= '0;
         state_q      <= ST_NORMAL;
         hold_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         led_q        <= '0;
         ovr_active_q <= 1'b0;
      end else begin
         btn_db_q     <= btn_db_d;
         btn_rise_q   <= btn_rise_d;
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         led_q        <= led_d;
         ovr_active_q <= ovr_active_d;
      end
   end

   // A new press always wins, including the cycle the hold would expire.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_NORMAL: begin
            hold_cnt_d = '0;
            if (any_btn) state_d = ST_OVERRIDE;
         end
         ST_OVERRIDE: begin
            hold_cnt_d = '0;
            if (!any_btn) state_d = (HOLD_CYCLES > 0) ? ST_HOLD : ST_NORMAL;
         end
         ST_HOLD: begin
            if (any_btn) begin
               state_d    = ST_OVERRIDE;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_NORMAL;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         default: begin
            state_d    = ST_NORMAL;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Blink phase restarts only on entry from NORMAL; HOLD<->OVERRIDE leaves it running.
   always_comb begin
      blink_cnt_d  = '0;
      phase_d      = 1'b0;
      led_d        = sw_dec;
      ovr_active_d = 1'b0;
      if (state_d != ST_NORMAL) begin
         if (state_q == ST_NORMAL) begin
            phase_d = 1'b1;
         end else if (blink_cnt_q == BLINK_LAST) begin
            phase_d = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            phase_d     = phase_q;
         end
         led_d        = (BLINK_EN && !phase_d) ? '0 : OVR_PATTERN;
         ovr_active_d = 1'b1;
      end
   end

   assign led        = led_q;
   assign btn_db     = btn_db_q;
   assign btn_rise   = btn_rise_q;
   assign ovr_active = ovr_active_q;

endmodule
